// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module     : univ_shift_reg
// Description: WIDTH-bit universal register (hold/shift/rotate/load/clear/
//              invert) with a shift counter and word-complete strobe.
// Revision   : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_shift;

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        is_shift = 1'b0;
        if (en) begin
            done_d = 1'b0;
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR: begin
                    q_d      = {sin_msb, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], sin_lsb};
                    is_shift = 1'b1;
                end
                MODE_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                MODE_CLR: begin
                    q_d   = RESET_VAL;
                    cnt_d = '0;
                end
                MODE_INV: q_d = ~q_q;
                default:  q_d = q_q;
            endcase
            // The WIDTH-th shift wraps the counter and raises the strobe on the same edge.
            if (is_shift) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q         = q_q;
    assign qb        = ~q_q;
    assign sout_lsb  = q_q[0];
    assign sout_msb  = q_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign word_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module     : tb_univ_shift_reg
// Description: Directed and random checks of four univ_shift_reg instances
//              against a behavioural model of the register rules.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [2:0]  mode = 3'b000;
    logic        sin_msb = 1'b0;
    logic        sin_lsb = 1'b0;
    logic [15:0] d = 16'h0;

    always #5 clk = ~clk;

    logic [7:0]  q0, qb0, q1, qb1;
    logic [3:0]  q2, qb2;
    logic [15:0] q3, qb3;
    logic [3:0]  c0, c1;
    logic [2:0]  c2;
    logic [4:0]  c3;
    logic        sl0, sm0, dn0, sl1, sm1, dn1, sl2, sm2, dn2, sl3, sm3, dn3;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_msb(sin_msb),
        .sin_lsb(sin_lsb), .d(d[7:0]), .q(q0), .qb(qb0), .sout_lsb(sl0),
        .sout_msb(sm0), .shift_cnt(c0), .word_done(dn0));
    univ_shift_reg #(.WIDTH(8)) u1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_msb(sin_msb),
        .sin_lsb(sin_lsb), .d(d[7:0]), .q(q1), .qb(qb1), .sout_lsb(sl1),
        .sout_msb(sm1), .shift_cnt(c1), .word_done(dn1));
    univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h9)) u2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_msb(sin_msb),
        .sin_lsb(sin_lsb), .d(d[3:0]), .q(q2), .qb(qb2), .sout_lsb(sl2),
        .sout_msb(sm2), .shift_cnt(c2), .word_done(dn2));
    univ_shift_reg #(.WIDTH(16), .RESET_VAL(16'hBEEF)) u3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_msb(sin_msb),
        .sin_lsb(sin_lsb), .d(d), .q(q3), .qb(qb3), .sout_lsb(sl3),
        .sout_msb(sm3), .shift_cnt(c3), .word_done(dn3));

    logic [31:0] oq[4], oqb[4], ocnt[4];
    logic        osl[4], osm[4], odn[4];
    assign oq[0] = 32'(q0);  assign oqb[0] = 32'(qb0); assign ocnt[0] = 32'(c0);
    assign oq[1] = 32'(q1);  assign oqb[1] = 32'(qb1); assign ocnt[1] = 32'(c1);
    assign oq[2] = 32'(q2);  assign oqb[2] = 32'(qb2); assign ocnt[2] = 32'(c2);
    assign oq[3] = 32'(q3);  assign oqb[3] = 32'(qb3); assign ocnt[3] = 32'(c3);
    assign osl[0] = sl0; assign osm[0] = sm0; assign odn[0] = dn0;
    assign osl[1] = sl1; assign osm[1] = sm1; assign odn[1] = dn1;
    assign osl[2] = sl2; assign osm[2] = sm2; assign odn[2] = dn2;
    assign osl[3] = sl3; assign osm[3] = sm3; assign odn[3] = dn3;

    int          WD[4] = '{8, 8, 4, 16};
    logic [31:0] RV[4] = '{32'hA5, 32'h0, 32'h9, 32'hBEEF};
    logic [31:0] mq[4];
    int          mcnt[4];
    bit          mdone[4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the register as a number, shifts and rotates as arithmetic.
    task automatic model_edge(input bit r, input bit e, input logic [2:0] m,
                              input bit sm, input bit sl, input logic [15:0] dd);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] mask;
            int w;
            w    = WD[i];
            mask = (32'd1 << w) - 32'd1;
            if (r) begin
                mq[i] = RV[i]; mcnt[i] = 0; mdone[i] = 0;
            end else if (e) begin
                case (m)
                    3'd1: mq[i] = (mq[i] >> 1) | (32'(sm) << (w - 1));
                    3'd2: mq[i] = ((mq[i] << 1) | 32'(sl)) & mask;
                    3'd3: mq[i] = (mq[i] >> 1) | ((mq[i] & 32'd1) << (w - 1));
                    3'd4: mq[i] = ((mq[i] << 1) | (mq[i] >> (w - 1))) & mask;
                    3'd5: mq[i] = 32'(dd) & mask;
                    3'd6: mq[i] = RV[i];
                    3'd7: mq[i] = ~mq[i] & mask;
                    default: ;
                endcase
                if (m >= 3'd1 && m <= 3'd4) begin
                    mcnt[i] = mcnt[i] + 1;
                    mdone[i] = (mcnt[i] == w);
                    if (mcnt[i] == w) mcnt[i] = 0;
                end else begin
                    if (m == 3'd5 || m == 3'd6) mcnt[i] = 0;
                    mdone[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] mask;
            mask = (32'd1 << WD[i]) - 32'd1;
            chk($sformatf("q[%0d]", i), oq[i], mq[i]);
            chk($sformatf("qb[%0d]", i), oqb[i], ~mq[i] & mask);
            chk($sformatf("sout_lsb[%0d]", i), 32'(osl[i]), mq[i] & 32'd1);
            chk($sformatf("sout_msb[%0d]", i), 32'(osm[i]), (mq[i] >> (WD[i] - 1)) & 32'd1);
            chk($sformatf("cnt[%0d]", i), ocnt[i], 32'(mcnt[i]));
            chk($sformatf("done[%0d]", i), 32'(odn[i]), 32'(mdone[i]));
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [2:0] m,
                        input bit sm, input bit sl, input logic [15:0] dd);
        reset = r; en = e; mode = m; sin_msb = sm; sin_lsb = sl; d = dd;
        @(posedge clk);
        model_edge(r, e, m, sm, sl, dd);
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] sipo, piso;
        int         pulses;

        // Reset dominates a pending LOAD.
        step(1, 1, 3'd5, 0, 0, 16'h00FF);
        step(1, 1, 3'd5, 0, 0, 16'h00FF);
        chk("rst_q", 32'(q0), 32'hA5);
        chk("rst_qb", 32'(qb0), 32'h5A);
        chk("rst_cnt", 32'(c0), 32'd0);
        chk("rst_done", 32'(dn0), 32'd0);

        // Load, hold, then stalled shifts.
        step(0, 1, 3'd5, 0, 0, 16'h003C);
        for (int k = 0; k < 3; k++) step(0, 1, 3'd0, 1, 1, 16'h0);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 3'd1, 1, 1, 16'h0);
            chk("hold_q", 32'(q0), 32'h3C);
            chk("hold_cnt", 32'(c0), 32'd0);
        end

        // SIPO.
        sipo = 8'b1011_0010;
        step(0, 1, 3'd6, 0, 0, 16'h0);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 3'd1, sipo[k], 0, 16'h0);
            chk("sipo_done", 32'(dn1), 32'(k == 7));
        end
        chk("sipo_q", 32'(q1), 32'hB2);
        chk("sipo_cnt", 32'(c1), 32'd0);

        // PISO.
        piso = 8'hC3;
        pulses = 0;
        step(0, 1, 3'd5, 0, 0, 16'h00C3);
        for (int k = 0; k < 8; k++) begin
            chk("piso_sout", 32'(sm0), 32'(piso[7-k]));
            step(0, 1, 3'd2, 0, 0, 16'h0);
            pulses += int'(dn0);
        end
        chk("piso_q", 32'(q0), 32'h00);
        chk("piso_pulses", 32'(pulses), 32'd1);

        // Rotate / invert: ROR+ROL count 2, INV does not, so the 6th ROL completes 8.
        step(0, 1, 3'd5, 0, 0, 16'h0081);
        step(0, 1, 3'd3, 0, 0, 16'h0);
        chk("ror_q", 32'(q0), 32'hC0);
        step(0, 1, 3'd4, 0, 0, 16'h0);
        chk("rol_q", 32'(q0), 32'h81);
        step(0, 1, 3'd7, 0, 0, 16'h0);
        chk("inv_q", 32'(q0), 32'h7E);
        chk("inv_cnt", 32'(c0), 32'd2);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 3'd4, 0, 0, 16'h0);
            chk("rol8_done", 32'(dn0), 32'(k == 5));
        end
        chk("rol8_q", 32'(q0), 32'h7E);

        // Reset mid-word discards the partial count.
        step(0, 1, 3'd6, 0, 0, 16'h0);
        for (int k = 0; k < 5; k++) step(0, 1, 3'd1, 1, 0, 16'h0);
        chk("mid_cnt", 32'(c0), 32'd5);
        step(1, 1, 3'd1, 1, 0, 16'h0);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 3'd1, k[0], 0, 16'h0);
            chk("mid_done", 32'(dn0), 32'(k == 7));
        end

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
